if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage_pkg.sv | 9 +
 rtl/if_fetch_stage_if_id_reg.sv | 20 ++
 rtl/if_fetch_stage.sv | 69 ++++++
 tb/tb_if_fetch_stage.sv | 103 ++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: fetch FSM state type, PCSrc encodings and default bubble instruction
package if_fetch_stage_pkg;
  typedef enum logic {FETCH, WAIT} state_t;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble beats load beats hold. Ports: clk, rst, load, bubble, inst_d, pcplus4_d -> inst, pcplus4, valid
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] inst_d,
  input  logic [31:0] pcplus4_d,
  output logic [31:0] inst,
  output logic [31:0] pcplus4,
  output logic        valid
);
  always_ff @(posedge clk or posedge rst)
    if (rst || bubble) {inst, pcplus4, valid} <= {NOP_INST, 32'd0, 1'b0};
    else if (load) {inst, pcplus4, valid} <= {inst_d, pcplus4_d, 1'b1};
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC + fetch FSM with deferred redirects over a ready-handshaked imem, feeding IF/ID. Ports: hazard controls (PCwrite, IFIDwrite), PCSrc + targets, imem req/addr/ready/rdata, IF/ID outputs
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCwrite,
  input  logic        IFIDwrite,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] JrAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_Inst,
  output logic [31:0] IFID_PCplus4,
  output logic        IFID_valid,
  output logic [4:0]  IFID_Rs,
  output logic [4:0]  IFID_Rt
);
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, pc_plus4, target, redir_addr, redir_addr_nx;
  logic redir_pend, redir_pend_nx, done, redir, discard;
  assign imem_addr = pc;
  assign done = imem_req & imem_ready;
  assign redir = PCwrite & (PCSrc != PCSRC_SEQ);
  assign discard = done & redir_pend;
  assign pc_plus4 = pc + 32'd4;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      redir_pend <= 1'b0;
      redir_addr <= 32'd0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      redir_pend <= redir_pend_nx;
      redir_addr <= redir_addr_nx;
    end
  // A redirect that cannot take effect yet is parked so the outstanding address stays stable.
  always_comb begin
    imem_req = !rst && (state == FETCH || state == WAIT);
    target = PCSrc == PCSRC_BR ? BranchAddr : PCSrc == PCSRC_J ? JumpAddr : JrAddr;
    target[1:0] = 2'b00;
    state_nx = done ? FETCH : WAIT;
    pc_nx = !done ? pc : redir ? target : redir_pend ? redir_addr : PCwrite ? pc_plus4 : pc;
    redir_pend_nx = done ? 1'b0 : redir_pend | redir;
    redir_addr_nx = !done && redir ? target : redir_addr;
  end
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk(clk),
    .rst(rst),
    .load(IFIDwrite & done),
    .bubble(redir | discard | (IFIDwrite & ~done)),
    .inst_d(imem_rdata),
    .pcplus4_d(pc_plus4),
    .inst(IFID_Inst),
    .pcplus4(IFID_PCplus4),
    .valid(IFID_valid)
  );
  assign IFID_Rs = IFID_Inst[25:21];
  assign IFID_Rt = IFID_Inst[20:16];
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of fetch sequencing, stalls, wait states, redirects, wrap and reset
module tb_if_fetch_stage;
  logic clk = 0, rst = 1, PCwrite = 1, IFIDwrite = 1, imem_ready = 1;
  logic [1:0] PCSrc = 2'b00;
  logic [31:0] BranchAddr = 0, JumpAddr = 0, JrAddr = 0;
  logic imem_req, IFID_valid;
  logic [31:0] imem_addr, imem_rdata, IFID_Inst, IFID_PCplus4;
  logic [4:0] IFID_Rs, IFID_Rt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign imem_rdata = 32'h03E2_0000 | {16'd0, imem_addr[15:0]};
  if_fetch_stage dut (
    .clk(clk), .rst(rst), .PCwrite(PCwrite), .IFIDwrite(IFIDwrite), .PCSrc(PCSrc),
    .BranchAddr(BranchAddr), .JumpAddr(JumpAddr), .JrAddr(JrAddr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IFID_Inst(IFID_Inst), .IFID_PCplus4(IFID_PCplus4), .IFID_valid(IFID_valid),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_if(input string tag, input logic [31:0] addr, input logic v, input logic [31:0] pc4);
    chk({tag, "_addr"}, imem_addr, addr);
    chk({tag, "_valid"}, {31'd0, IFID_valid}, {31'd0, v});
    if (v) chk({tag, "_pc4"}, IFID_PCplus4, pc4);
  endtask
  initial begin
    step; step;
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", {31'd0, IFID_valid}, 0);
    chk("rst_inst", IFID_Inst, 0);
    chk("rst_pc4", IFID_PCplus4, 0);
    rst = 0;
    #1;
    chk("rel_req", {31'd0, imem_req}, 1);
    chk("rel_addr", imem_addr, 0);
    step; chk_if("seq1", 32'h4, 1, 32'h4);
    chk("seq1_inst", IFID_Inst, 32'h03E2_0000);
    chk("seq1_rs", {27'd0, IFID_Rs}, 31);
    chk("seq1_rt", {27'd0, IFID_Rt}, 2);
    step; chk_if("seq2", 32'h8, 1, 32'h8);
    PCwrite = 0; IFIDwrite = 0;
    step; chk_if("stall", 32'h8, 1, 32'h8);
    chk("stall_inst", IFID_Inst, 32'h03E2_0004);
    PCwrite = 1; IFIDwrite = 1;
    step; chk_if("refetch", 32'hC, 1, 32'hC);
    chk("refetch_inst", IFID_Inst, 32'h03E2_0008);
    step; chk_if("seq3", 32'h10, 1, 32'h10);
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step; chk_if("wait", 32'h10, 0, 0);
    end
    imem_ready = 1;
    step; chk_if("wait_done", 32'h14, 1, 32'h14);
    chk("wait_done_inst", IFID_Inst, 32'h03E2_0010);
    imem_ready = 0;
    step; chk_if("br_w0", 32'h14, 0, 0);
    PCSrc = 2'b01; BranchAddr = 32'h43;
    step; chk_if("br_cap", 32'h14, 0, 0);
    PCSrc = 2'b00;
    step; chk_if("br_hold", 32'h14, 0, 0);
    imem_ready = 1;
    step; chk_if("br_disc", 32'h40, 0, 0);
    step; chk_if("br_tgt", 32'h44, 1, 32'h44);
    chk("br_tgt_inst", IFID_Inst, 32'h03E2_0040);
    PCSrc = 2'b10; JumpAddr = 32'h100;
    step; chk_if("jmp", 32'h100, 0, 0);
    chk("jmp_inst", IFID_Inst, 0);
    PCSrc = 2'b00;
    step; chk_if("jmp_tgt", 32'h104, 1, 32'h104);
    PCSrc = 2'b11; JrAddr = 32'hFFFF_FFFE;
    step; chk_if("jr", 32'hFFFF_FFFC, 0, 0);
    PCSrc = 2'b00;
    step; chk_if("wrap", 32'h0, 1, 32'h0);
    PCwrite = 0; PCSrc = 2'b01; BranchAddr = 32'h200;
    step; chk_if("blk", 32'h0, 1, 32'h4);
    PCwrite = 1; PCSrc = 2'b00;
    step; chk_if("blk_after", 32'h4, 1, 32'h4);
    imem_ready = 0; PCSrc = 2'b01; BranchAddr = 32'h80;
    step; chk_if("pend", 32'h4, 0, 0);
    PCSrc = 2'b00;
    rst = 1;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 0);
    chk("mid_rst_addr", imem_addr, 0);
    step;
    rst = 0; imem_ready = 1;
    #1;
    chk("mid_rel_addr", imem_addr, 0);
    step; chk_if("post_rst", 32'h4, 1, 32'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
